// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder: FSM state codes,
// address-decode classes, the LED register address and default widths.
package mem_bus_pkg;

   localparam int DEF_DATA_W = 9;
   localparam int DEF_ADDR_W = 9;

   localparam logic [8:0] LED_ADDR = 9'h1FF;

   typedef logic [1:0] state_t;
   localparam state_t IDLE    = 2'd0;
   localparam state_t RD_WAIT = 2'd1;
   localparam state_t RD_RSP  = 2'd2;
   localparam state_t WR      = 2'd3;

   typedef enum logic [1:0] {
      SEL_RAM  = 2'd0,
      SEL_LED  = 2'd1,
      SEL_NONE = 2'd2
   } sel_t;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with a registered read; contents are never reset.
module mem_bus_ram #(
   parameter int DATA_W    = 9,
   parameter int RAM_DEPTH = 128,
   parameter int RAM_AW    = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [RAM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [RAM_DEPTH];

   // read-before-write port: q always reflects the word addressed last cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 9-bit processor port: RAM, fixed read latency,
// sticky error flags. Optional LED register at 9'h1FF enabled by macro LED_REG_EN.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int RAM_DEPTH    = 128,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              wr_done,
   output logic              addr_err,
   output logic              req_drop,
   output logic [DATA_W-1:0] led_o
);

   localparam int         RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

`ifdef LED_REG_EN
   localparam logic LED_MAPPED = 1'b1;
`else
   localparam logic LED_MAPPED = 1'b0;
`endif

   state_t            state;
   state_t            state_nx;
   logic [2:0]        lat_cnt;
   logic [RAM_AW-1:0] ram_idx;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_hold;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] ram_q;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic              accept;
   sel_t              sel_in;
   sel_t              sel_q;

   assign accept = req_valid & req_ready;

   // classify the incoming address
   always_comb begin
      if (int'(req_addr) < RAM_DEPTH) begin
         sel_in = SEL_RAM;
      end else if (LED_MAPPED && (req_addr == ADDR_W'(LED_ADDR))) begin
         sel_in = SEL_LED;
      end else begin
         sel_in = SEL_NONE;
      end
   end

   // next-state logic; latency 1 skips RD_WAIT entirely
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_we) begin
                  state_nx = WR;
               end else if (READ_LATENCY == 1) begin
                  state_nx = RD_RSP;
               end else begin
                  state_nx = RD_WAIT;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         RD_WAIT: begin
            if (lat_cnt == 3'd1) begin
               state_nx = RD_RSP;
            end else begin
               state_nx = RD_WAIT;
            end
         end
         RD_RSP:  state_nx = IDLE;
         WR:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM, request capture, handshake pulses and sticky flags
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         wr_done    <= 1'b0;
         addr_err   <= 1'b0;
         req_drop   <= 1'b0;
         lat_cnt    <= 3'd0;
         ram_idx    <= '0;
         wdata_q    <= '0;
         sel_q      <= SEL_NONE;
         rdata_hold <= '0;
      end else begin
         state     <= state_nx;
         req_ready <= (state_nx == IDLE);
         rsp_valid <= (state_nx == RD_RSP);
         wr_done   <= (state == WR);
         if (accept) begin
            ram_idx <= req_addr[RAM_AW-1:0];
            wdata_q <= req_wdata;
            sel_q   <= sel_in;
            lat_cnt <= LAT_LOAD;
            if (sel_in == SEL_NONE) begin
               addr_err <= 1'b1;
            end
         end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
         end
         if (req_valid && !req_ready) begin
            req_drop <= 1'b1;
         end
         if (rsp_valid) begin
            rdata_hold <= rd_word;
         end
      end
   end

   // RAM is read every cycle; the last cycle before RD_RSP addresses the target
   // word so its registered output is valid throughout RD_RSP
   always_comb begin
      if (state == IDLE) begin
         ram_addr = req_addr[RAM_AW-1:0];
      end else begin
         ram_addr = ram_idx;
      end
   end

   // reset during WR must block the commit
   assign ram_we = (state == WR) && (sel_q == SEL_RAM) && resetn;

   mem_bus_ram #(
      .DATA_W    (DATA_W),
      .RAM_DEPTH (RAM_DEPTH),
      .RAM_AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .q     (ram_q)
   );

   // source of the read word; unmapped reads return zero
   always_comb begin
      case (sel_q)
         SEL_RAM: rd_word = ram_q;
         SEL_LED: rd_word = led_o;
         default: rd_word = '0;
      endcase
   end

   assign rsp_rdata = rsp_valid ? rd_word : rdata_hold;

`ifdef LED_REG_EN
   // LED register loads at the end of WR
   always_ff @(posedge clk) begin
      if (!resetn) begin
         led_o <= '0;
      end else if ((state == WR) && (sel_q == SEL_LED)) begin
         led_o <= wdata_q;
      end
   end
`else
   assign led_o = '0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: three instances (latency 2, 1 and 5).
module tb_mem_bus_responder;

   logic            clk;
   logic            resetn;
   logic            req_we;
   logic [8:0]      req_addr;
   logic [8:0]      req_wdata;
   logic [2:0]      v_valid;
   logic [2:0]      v_ready;
   logic [2:0]      v_rsp_valid;
   logic [2:0]      v_wr_done;
   logic [2:0]      v_addr_err;
   logic [2:0]      v_req_drop;
   logic [2:0][8:0] v_rdata;
   logic [2:0][8:0] v_led;

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_bus_responder #(.READ_LATENCY(2)) dut (
      .clk(clk), .resetn(resetn), .req_valid(v_valid[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(v_ready[0]),
      .rsp_valid(v_rsp_valid[0]), .rsp_rdata(v_rdata[0]), .wr_done(v_wr_done[0]),
      .addr_err(v_addr_err[0]), .req_drop(v_req_drop[0]), .led_o(v_led[0])
   );

   mem_bus_responder #(.READ_LATENCY(1)) dut_l1 (
      .clk(clk), .resetn(resetn), .req_valid(v_valid[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(v_ready[1]),
      .rsp_valid(v_rsp_valid[1]), .rsp_rdata(v_rdata[1]), .wr_done(v_wr_done[1]),
      .addr_err(v_addr_err[1]), .req_drop(v_req_drop[1]), .led_o(v_led[1])
   );

   mem_bus_responder #(.READ_LATENCY(5)) dut_l5 (
      .clk(clk), .resetn(resetn), .req_valid(v_valid[2]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(v_ready[2]),
      .rsp_valid(v_rsp_valid[2]), .rsp_rdata(v_rdata[2]), .wr_done(v_wr_done[2]),
      .addr_err(v_addr_err[2]), .req_drop(v_req_drop[2]), .led_o(v_led[2])
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one request to instance d; lat counts cycles with the acceptance
   // cycle as 0. One extra cycle is then stepped to observe the pulse width.
   task automatic bus_op(input int d, input logic we, input logic [8:0] a,
                         input logic [8:0] wd, output int lat, output logic [8:0] rd,
                         output logic pulse_after, output logic [8:0] rd_after);
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      v_valid[d] = 1'b1;
      tick();
      v_valid[d] = 1'b0;
      lat = 1;
      while (!(we ? v_wr_done[d] : v_rsp_valid[d]) && lat < 20) begin
         tick();
         lat++;
      end
      rd = v_rdata[d];
      tick();
      pulse_after = we ? v_wr_done[d] : v_rsp_valid[d];
      rd_after    = v_rdata[d];
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      v_valid = 3'b000;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({v_ready[d], v_rsp_valid[d], v_rdata[d], v_wr_done[d], v_addr_err[d],
              v_req_drop[d], v_led[d]} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got ready=%b rv=%b rd=%h wd=%b ae=%b dr=%b led=%h, expected all 0",
                     d, v_ready[d], v_rsp_valid[d], v_rdata[d], v_wr_done[d],
                     v_addr_err[d], v_req_drop[d], v_led[d]);
         end
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (v_ready !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_reset: got %b expected 111", v_ready);
      end
   endtask

   task automatic test_write_read();
      int lat;
      logic [8:0] rd, rd_after;
      logic pa;
      bus_op(0, 1'b1, 9'd3, 9'h0A5, lat, rd, pa, rd_after);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL wr_done_latency: got %0d expected 2", lat);
      end
      checks++;
      if (pa !== 1'b0) begin
         errors++;
         $display("FAIL wr_done_width: got %b expected 0", pa);
      end
      bus_op(0, 1'b0, 9'd3, 9'h000, lat, rd, pa, rd_after);
      checks++;
      if (lat !== 2 || rd !== 9'h0A5) begin
         errors++;
         $display("FAIL read_addr3: got lat=%0d data=%h expected lat=2 data=0a5", lat, rd);
      end
      checks++;
      if (pa !== 1'b0 || rd_after !== 9'h0A5) begin
         errors++;
         $display("FAIL rsp_pulse_hold: got valid=%b data=%h expected valid=0 data=0a5", pa, rd_after);
      end
      checks++;
      if (v_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_read: got %b expected 1", v_ready[0]);
      end
      bus_op(0, 1'b1, 9'd4, 9'h001, lat, rd, pa, rd_after);
      checks++;
      if (v_addr_err[0] !== 1'b0 || v_req_drop[0] !== 1'b0) begin
         errors++;
         $display("FAIL flags_clean: got ae=%b dr=%b expected 0 0", v_addr_err[0], v_req_drop[0]);
      end
   endtask

   task automatic test_latency_sweep();
      int lat;
      logic [8:0] rd, rd_after;
      logic pa;
      int exp_lat;
      for (int d = 1; d < 3; d++) begin
         exp_lat = (d == 1) ? 1 : 5;
         bus_op(d, 1'b1, 9'd10, 9'h111, lat, rd, pa, rd_after);
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL sweep_write dut%0d: got lat=%0d expected 2", d, lat);
         end
         bus_op(d, 1'b0, 9'd10, 9'h000, lat, rd, pa, rd_after);
         checks++;
         if (lat !== exp_lat || rd !== 9'h111) begin
            errors++;
            $display("FAIL sweep_read dut%0d: got lat=%0d data=%h expected lat=%0d data=111",
                     d, lat, rd, exp_lat);
         end
         checks++;
         if (pa !== 1'b0 || rd_after !== 9'h111) begin
            errors++;
            $display("FAIL sweep_hold dut%0d: got valid=%b data=%h expected 0 111", d, pa, rd_after);
         end
      end
   endtask

   task automatic test_busy_drop();
      int extra;
      req_we    = 1'b0;
      req_addr  = 9'd3;
      req_wdata = 9'h000;
      v_valid[0] = 1'b1;
      tick();
      req_addr = 9'd5;
      tick();
      v_valid[0] = 1'b0;
      checks++;
      if (v_rsp_valid[0] !== 1'b1 || v_rdata[0] !== 9'h0A5) begin
         errors++;
         $display("FAIL busy_read: got valid=%b data=%h expected 1 0a5", v_rsp_valid[0], v_rdata[0]);
      end
      checks++;
      if (v_req_drop[0] !== 1'b1) begin
         errors++;
         $display("FAIL req_drop_set: got %b expected 1", v_req_drop[0]);
      end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (v_rsp_valid[0] === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0 || v_req_drop[0] !== 1'b1) begin
         errors++;
         $display("FAIL busy_no_second_rsp: got extra=%0d drop=%b expected 0 1", extra, v_req_drop[0]);
      end
   endtask

   task automatic test_unmapped();
      int lat;
      logic [8:0] rd, rd_after;
      logic pa;
      bus_op(0, 1'b1, 9'h050, 9'h033, lat, rd, pa, rd_after);
      bus_op(0, 1'b1, 9'h150, 9'h1AB, lat, rd, pa, rd_after);
      checks++;
      if (lat !== 2 || v_addr_err[0] !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_write: got lat=%0d ae=%b expected 2 1", lat, v_addr_err[0]);
      end
      bus_op(0, 1'b0, 9'h050, 9'h000, lat, rd, pa, rd_after);
      checks++;
      if (rd !== 9'h033) begin
         errors++;
         $display("FAIL ram_unchanged: got %h expected 033", rd);
      end
      bus_op(0, 1'b0, 9'h150, 9'h000, lat, rd, pa, rd_after);
      checks++;
      if (lat !== 2 || rd !== 9'h000 || v_addr_err[0] !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_read: got lat=%0d data=%h ae=%b expected 2 000 1", lat, rd, v_addr_err[0]);
      end
   endtask

   task automatic test_led();
      int lat;
      logic [8:0] rd, rd_after;
      logic pa;
      bus_op(1, 1'b1, 9'h1FF, 9'h0F0, lat, rd, pa, rd_after);
      bus_op(1, 1'b0, 9'h1FF, 9'h000, lat, rd, pa, rd_after);
`ifdef LED_REG_EN
      checks++;
      if (v_led[1] !== 9'h0F0 || rd !== 9'h0F0 || v_addr_err[1] !== 1'b0) begin
         errors++;
         $display("FAIL led_enabled: got led=%h read=%h ae=%b expected 0f0 0f0 0", v_led[1], rd, v_addr_err[1]);
      end
`else
      checks++;
      if (v_led[1] !== 9'h000 || rd !== 9'h000 || v_addr_err[1] !== 1'b1) begin
         errors++;
         $display("FAIL led_disabled: got led=%h read=%h ae=%b expected 000 000 1", v_led[1], rd, v_addr_err[1]);
      end
`endif
   endtask

   task automatic test_reset_mid_write();
      int lat;
      int seen;
      logic [8:0] rd, rd_after;
      logic pa;
      req_we    = 1'b1;
      req_addr  = 9'd4;
      req_wdata = 9'h1C3;
      v_valid[0] = 1'b1;
      tick();
      v_valid[0] = 1'b0;
      resetn = 1'b0;
      tick();
      seen = (v_wr_done[0] === 1'b1) ? 1 : 0;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (v_wr_done[0] === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0 || v_ready[0] !== 1'b1 || v_addr_err[0] !== 1'b0 || v_req_drop[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_write: got wr_done_seen=%0d ready=%b ae=%b dr=%b expected 0 1 0 0",
                  seen, v_ready[0], v_addr_err[0], v_req_drop[0]);
      end
      bus_op(0, 1'b0, 9'd4, 9'h000, lat, rd, pa, rd_after);
      checks++;
      if (lat !== 2 || rd !== 9'h001) begin
         errors++;
         $display("FAIL write_aborted: got lat=%0d data=%h expected 2 001", lat, rd);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      resetn    = 1'b0;
      v_valid   = 3'b000;
      req_we    = 1'b0;
      req_addr  = 9'h000;
      req_wdata = 9'h000;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_latency_sweep();
      test_busy_drop();
      test_unmapped();
      test_led();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
